// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl
// Brief  : Pipeline hazard unit: forwarding, stall/flush priority, divide FSM.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              dmem_stall,
    input  logic              exceptM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              div_busy,
    output logic              div_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [7:0] c_DIV_LOAD = 8'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_div_start;
    logic w_lwstall;
    logic w_brstall;
    logic w_hit_e;
    logic w_hit_m;

    // ------------------------------------------------------------------
    // Forwarding: purely a function of register tags, never of stalls
    // ------------------------------------------------------------------
    always_comb begin
        forwardaE = 2'b00;
        forwardbE = 2'b00;
        if (rsE != '0 && rsE == writeregM && regwriteM)
            forwardaE = 2'b10;
        else if (rsE != '0 && rsE == writeregW && regwriteW)
            forwardaE = 2'b01;
        if (rtE != '0 && rtE == writeregM && regwriteM)
            forwardbE = 2'b10;
        else if (rtE != '0 && rtE == writeregW && regwriteW)
            forwardbE = 2'b01;
    end

    assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_lwstall = memtoregE && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));
    assign w_hit_e   = regwriteE && (writeregE != '0) &&
                       ((writeregE == rsD) || (writeregE == rtD));
    assign w_hit_m   = memtoregM && (writeregM != '0) &&
                       ((writeregM == rsD) || (writeregM == rtD));
    assign w_brstall = branchD && (w_hit_e || w_hit_m);

    // ------------------------------------------------------------------
    // Divider occupancy FSM
    // ------------------------------------------------------------------
    assign w_div_start = (r_state == IDLE) && divE && !exceptM && !dmem_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (exceptM) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_div_start) begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = c_DIV_LOAD;
                    end
                end
                BUSY: begin
                    // Count reaching zero on this edge ends the busy phase
                    if (!dmem_stall) begin
                        w_cnt_nxt = r_cnt - 8'd1;
                        if (r_cnt <= 8'd1) begin
                            w_state_nxt = DONE;
                            w_cnt_nxt   = 8'd0;
                        end
                    end
                end
                DONE:    w_state_nxt = IDLE;
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall / flush priority; everything held low while in reset
    // ------------------------------------------------------------------
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        flushW   = 1'b0;
        div_busy = 1'b0;
        div_done = 1'b0;
        if (resetn) begin
            div_busy = (r_state == BUSY) || w_div_start;
            div_done = (r_state == DONE);
            if (exceptM) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end else if (dmem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (div_busy) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (w_lwstall || w_brstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_stall_cnt <= '0;
        else if (stallF && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Self-checking bench for hazard_ctrl (DIV_CYCLES=4, CNT_W=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       resetn;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       branchD, regwriteE, memtoregE, divE;
    logic       regwriteM, memtoregM, regwriteW, dmem_stall, exceptM;
    logic       stallF, stallD, stallE, stallM;
    logic       flushD, flushE, flushM, flushW;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       div_busy, div_done;
    logic [7:0] stall_cnt;

    hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .divE(divE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .writeregW(writeregW), .regwriteW(regwriteW),
        .dmem_stall(dmem_stall), .exceptM(exceptM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
    );

    // {stallF,D,E,M, flushD,E,M,W, fwdaD,fwdbD, fwdaE, fwdbE, busy,done}
    wire [15:0] w_obs = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
                         forwardaD, forwardbD, forwardaE, forwardbE, div_busy, div_done};

    logic [15:0] exp_q[$];
    logic [7:0]  exp_cnt;
    int          n_vec;
    int          n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] st, input logic [3:0] fl,
                                       input logic [1:0] fd, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic [1:0] dv);
        return {st, fl, fd, fa, fb, dv};
    endfunction

    task automatic clear_inputs();
        rsD = '0; rtD = '0; branchD = 0; rsE = '0; rtE = '0; writeregE = '0;
        regwriteE = 0; memtoregE = 0; divE = 0; writeregM = '0; regwriteM = 0;
        memtoregM = 0; writeregW = '0; regwriteW = 0; dmem_stall = 0; exceptM = 0;
    endtask

    localparam logic [15:0] c_ZERO = 16'h0000;
    localparam logic [3:0]  c_LU   = 4'b1100;

    task automatic test_reset();
        logic [15:0] want;
        clear_inputs();
        memtoregE = 1; rtE = 8; rsD = 8; dmem_stall = 1; divE = 1; branchD = 1;
        resetn = 0;
        exp_q.push_back(c_ZERO);
        #3;
        want = exp_q.pop_front();
        n_vec++;
        if (w_obs !== want) begin
            n_err++; $display("FAIL reset_hold: got %b want %b", w_obs, want);
        end
        n_vec++;
        if (stall_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        resetn = 1;
        exp_cnt = 8'd0;
        @(posedge clk); #1;
        exp_q.push_back(c_ZERO);
        @(negedge clk);
        want = exp_q.pop_front();
        n_vec++;
        if (w_obs !== want) begin
            n_err++; $display("FAIL reset_release: got %b want %b", w_obs, want);
        end
    endtask

    task automatic test_load_use();
        logic [15:0] want;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin memtoregE = 1; rtE = 8; rsD = 8;
                         exp_q.push_back(mk(c_LU, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b00)); end
                1: begin memtoregE = 1; rtE = 0; rsD = 0;
                         exp_q.push_back(c_ZERO); end
                2: begin memtoregE = 1; rtE = 8; rtD = 8;
                         exp_q.push_back(mk(c_LU, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b00)); end
                default: begin memtoregE = 0; rtE = 8; rsD = 8;
                         exp_q.push_back(c_ZERO); end
            endcase
            @(negedge clk);
            want = exp_q.pop_front();
            n_vec++;
            if (w_obs !== want) begin
                n_err++; $display("FAIL load_use[%0d]: got %b want %b", i, w_obs, want);
            end
            if (want[15] && exp_cnt != 8'hFF) exp_cnt++;
        end
        @(posedge clk); #1; clear_inputs();
        n_vec++;
        if (stall_cnt !== exp_cnt) begin
            n_err++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_forward();
        logic [15:0] want;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin rsE = 3; rtE = 3; writeregM = 3; writeregW = 3;
                         regwriteM = 1; regwriteW = 1; rsD = 3; rtD = 4;
                         exp_q.push_back(mk(4'b0000, 4'b0000, 2'b10, 2'b10, 2'b10, 2'b00)); end
                1: begin rsE = 3; rtE = 3; writeregM = 3; writeregW = 3;
                         regwriteM = 0; regwriteW = 1; rsD = 3; rtD = 4;
                         exp_q.push_back(mk(4'b0000, 4'b0000, 2'b00, 2'b01, 2'b01, 2'b00)); end
                2: begin rsE = 0; rtE = 3; writeregM = 0; writeregW = 3;
                         regwriteM = 1; regwriteW = 1;
                         exp_q.push_back(mk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00)); end
                3: begin rsE = 3; rtE = 7; writeregM = 3; writeregW = 7;
                         regwriteM = 1; regwriteW = 1; rsD = 3; rtD = 4;
                         exp_q.push_back(mk(4'b0000, 4'b0000, 2'b10, 2'b10, 2'b01, 2'b00)); end
                default: begin rsE = 3; rtE = 7; writeregM = 3; writeregW = 7;
                         regwriteM = 1; regwriteW = 1; rsD = 3; rtD = 4; dmem_stall = 1;
                         exp_q.push_back(mk(4'b1111, 4'b0001, 2'b10, 2'b10, 2'b01, 2'b00)); end
            endcase
            @(negedge clk);
            want = exp_q.pop_front();
            n_vec++;
            if (w_obs !== want) begin
                n_err++; $display("FAIL forward[%0d]: got %b want %b", i, w_obs, want);
            end
            if (want[15] && exp_cnt != 8'hFF) exp_cnt++;
        end
        @(posedge clk); #1; clear_inputs();
    endtask

    task automatic test_branch();
        logic [15:0] want;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            branchD = 1;
            case (i)
                0: begin rsD = 5; writeregE = 5; regwriteE = 1;
                         exp_q.push_back(mk(c_LU, 4'b0100, 2'b00, 2'b00, 2'b00, 2'b00)); end
                1: begin rsD = 5; writeregM = 5; regwriteM = 1;
                         exp_q.push_back(mk(4'b0000, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b00)); end
                2: begin rsD = 5; writeregM = 5; regwriteM = 1; memtoregM = 1;
                         exp_q.push_back(mk(c_LU, 4'b0100, 2'b10, 2'b00, 2'b00, 2'b00)); end
                default: begin writeregE = 0; regwriteE = 1;
                         exp_q.push_back(c_ZERO); end
            endcase
            @(negedge clk);
            want = exp_q.pop_front();
            n_vec++;
            if (w_obs !== want) begin
                n_err++; $display("FAIL branch[%0d]: got %b want %b", i, w_obs, want);
            end
            if (want[15] && exp_cnt != 8'hFF) exp_cnt++;
        end
        @(posedge clk); #1; clear_inputs();
        n_vec++;
        if (stall_cnt !== exp_cnt) begin
            n_err++; $display("FAIL branch_cnt: got %0d want %0d", stall_cnt, exp_cnt);
        end
    endtask

    // Divide held in E: 4 stall cycles (start + 3 busy), done on the 5th
    task automatic test_divide();
        logic [15:0] want;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            divE = (i < 5);
            if (i < 4)
                exp_q.push_back(mk(4'b1110, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b10));
            else if (i == 4)
                exp_q.push_back(mk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01));
            else
                exp_q.push_back(c_ZERO);
            @(negedge clk);
            want = exp_q.pop_front();
            n_vec++;
            if (w_obs !== want) begin
                n_err++; $display("FAIL divide[%0d]: got %b want %b", i, w_obs, want);
            end
            if (want[15] && exp_cnt != 8'hFF) exp_cnt++;
        end
        @(posedge clk); #1; clear_inputs();
        n_vec++;
        if (stall_cnt !== exp_cnt) begin
            n_err++; $display("FAIL divide_cnt: got %0d want %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_divide_dmem();
        logic [15:0] want;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            divE = (i < 7);
            dmem_stall = (i == 2 || i == 3);
            if (i == 2 || i == 3)
                exp_q.push_back(mk(4'b1111, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b10));
            else if (i < 6)
                exp_q.push_back(mk(4'b1110, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b10));
            else if (i == 6)
                exp_q.push_back(mk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01));
            else
                exp_q.push_back(c_ZERO);
            @(negedge clk);
            want = exp_q.pop_front();
            n_vec++;
            if (w_obs !== want) begin
                n_err++; $display("FAIL divide_dmem[%0d]: got %b want %b", i, w_obs, want);
            end
            if (want[15] && exp_cnt != 8'hFF) exp_cnt++;
        end
        @(posedge clk); #1; clear_inputs();
        n_vec++;
        if (stall_cnt !== exp_cnt) begin
            n_err++; $display("FAIL divide_dmem_cnt: got %0d want %0d", stall_cnt, exp_cnt);
        end
    endtask

    task automatic test_except();
        logic [15:0] want;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0, 1: begin divE = 1;
                         exp_q.push_back(mk(4'b1110, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b10)); end
                2: begin divE = 1; exceptM = 1;
                         exp_q.push_back(mk(4'b0000, 4'b1110, 2'b00, 2'b00, 2'b00, 2'b10)); end
                3: exp_q.push_back(c_ZERO);
                4: begin exceptM = 1; dmem_stall = 1; memtoregE = 1; rtE = 8; rsD = 8;
                         exp_q.push_back(mk(4'b0000, 4'b1110, 2'b00, 2'b00, 2'b00, 2'b00)); end
                5: begin exceptM = 1; divE = 1;
                         exp_q.push_back(mk(4'b0000, 4'b1110, 2'b00, 2'b00, 2'b00, 2'b00)); end
                default: exp_q.push_back(c_ZERO);
            endcase
            @(negedge clk);
            want = exp_q.pop_front();
            n_vec++;
            if (w_obs !== want) begin
                n_err++; $display("FAIL except[%0d]: got %b want %b", i, w_obs, want);
            end
            if (want[15] && exp_cnt != 8'hFF) exp_cnt++;
        end
        @(posedge clk); #1; clear_inputs();
    endtask

    task automatic test_reset_mid_divide();
        logic [15:0] want;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            divE = 1;
            exp_q.push_back(mk(4'b1110, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b10));
            @(negedge clk);
            want = exp_q.pop_front();
            n_vec++;
            if (w_obs !== want) begin
                n_err++; $display("FAIL rst_mid_pre[%0d]: got %b want %b", i, w_obs, want);
            end
        end
        @(posedge clk); #2;
        resetn = 0;
        exp_cnt = 8'd0;
        exp_q.push_back(c_ZERO);
        #1;
        want = exp_q.pop_front();
        n_vec++;
        if (w_obs !== want) begin
            n_err++; $display("FAIL rst_mid_outputs: got %b want %b", w_obs, want);
        end
        n_vec++;
        if (stall_cnt !== exp_cnt) begin
            n_err++; $display("FAIL rst_mid_cnt: got %0d want %0d", stall_cnt, exp_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        resetn = 1;
        @(posedge clk); #1;
        exp_q.push_back(c_ZERO);
        @(negedge clk);
        want = exp_q.pop_front();
        n_vec++;
        if (w_obs !== want) begin
            n_err++; $display("FAIL rst_mid_release: got %b want %b", w_obs, want);
        end
    endtask

    task automatic test_saturate();
        int n;
        n = 254 - int'(exp_cnt);
        @(posedge clk); #1;
        clear_inputs();
        dmem_stall = 1;
        repeat (n) @(posedge clk);
        #1;
        n_vec++;
        if (stall_cnt !== 8'd254) begin
            n_err++; $display("FAIL sat_near_max: got %0d want 254", stall_cnt);
        end
        @(posedge clk); #1;
        n_vec++;
        if (stall_cnt !== 8'd255) begin
            n_err++; $display("FAIL sat_at_max: got %0d want 255", stall_cnt);
        end
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (stall_cnt !== 8'd255) begin
            n_err++; $display("FAIL sat_hold: got %0d want 255", stall_cnt);
        end
        clear_inputs();
        exp_cnt = 8'd255;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 8'd0;
        resetn  = 0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_divide();
        test_divide_dmem();
        test_except();
        test_reset_mid_divide();
        test_divide();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
